// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, column count and per-frame key classification.
package keypad_pkg;

    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } kp_state_t;

    typedef enum logic [1:0] {
        KEY_NONE  = 2'd0,
        KEY_ONE   = 2'd1,
        KEY_MULTI = 2'd2
    } key_class_t;

    // Two partial results combine to MULTI as soon as both saw a key.
    function automatic key_class_t merge_class(input key_class_t a, input key_class_t b);
        if (a == KEY_NONE)
            return b;
        if (b == KEY_NONE)
            return a;
        return KEY_MULTI;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column-slot timebase: one-cycle pulse on the last cycle of every SCAN_DIV-cycle slot.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debounce and a valid/ack key handshake.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_CNT   = 500
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_COLS-1:0] col_sel,
    input  logic [3:0]          row_in,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                overrun
);

    localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic       tick;
    logic [3:0] row_meta, row_sync;
    logic [1:0] col;
    key_class_t acc_class, col_class, frame_class;
    logic [3:0] acc_code, frame_code;
    logic [1:0] col_row;
    logic       frame_done, frame_match, accept;

    kp_state_t       state;
    logic [3:0]      cand;
    logic [DB_W-1:0] db_cnt;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Classify the current column's rows and fold them into the running frame result.
    always_comb begin
        col_class = KEY_NONE;
        col_row   = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                col_class = (col_class == KEY_NONE) ? KEY_ONE : KEY_MULTI;
                col_row   = 2'(r);
            end
        end
        frame_class = merge_class(acc_class, col_class);
        frame_code  = (col_class == KEY_ONE) ? {col_row, col} : acc_code;
    end

    assign frame_done  = tick && (col == 2'(NUM_COLS - 1));
    assign frame_match = frame_done && (frame_class == KEY_ONE) && (frame_code == cand);

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_meta  <= 4'b1111;
            row_sync  <= 4'b1111;
            col       <= 2'd0;
            col_sel   <= 4'b1110;
            acc_class <= KEY_NONE;
            acc_code  <= 4'd0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            if (tick) begin
                col     <= col + 2'd1;
                col_sel <= {col_sel[NUM_COLS-2:0], col_sel[NUM_COLS-1]};
                if (frame_done) begin
                    acc_class <= KEY_NONE;
                    acc_code  <= 4'd0;
                end else begin
                    acc_class <= frame_class;
                    acc_code  <= frame_code;
                end
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RP_W = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT + 1) : 1;
    localparam int REP_NEXT_CNT = (REPEAT_CNT / 4 > 0) ? REPEAT_CNT / 4 : 1;
    localparam logic [RP_W-1:0] RP_ONE = RP_W'(1);

    logic [RP_W-1:0] rep_cnt;
    logic            rep_first;
    logic            rep_due;

    // First repeat waits the long interval, later ones use the quarter interval.
    assign rep_due = rep_cnt >= (rep_first ? RP_W'(REPEAT_CNT - 1) : RP_W'(REP_NEXT_CNT - 1));
`else
    logic unused_repeat_cnt;
    assign unused_repeat_cnt = ^REPEAT_CNT;
`endif

    always_comb begin
        accept = 1'b0;
        if (frame_done) begin
            case (state)
                ST_IDLE:     accept = (frame_class == KEY_ONE) && (DEBOUNCE_CNT <= 1);
                ST_PRESS_DB: accept = frame_match && (db_cnt >= DB_LAST);
`ifdef KEYPAD_REPEAT_EN
                ST_HELD:     accept = frame_match && rep_due;
`endif
                default:     accept = 1'b0;
            endcase
        end
    end

    // An accept always wins over a same-cycle ack; an accept onto an unread key only flags overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cand      <= 4'd0;
            db_cnt    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            if (accept) begin
                if (!key_valid || key_ack) begin
                    key_code  <= frame_code;
                    key_valid <= 1'b1;
                    overrun   <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end

            if (frame_done) begin
                case (state)
                    ST_IDLE: begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
`endif
                        if (frame_class == KEY_ONE) begin
                            cand   <= frame_code;
                            db_cnt <= DB_ONE;
                            if (DEBOUNCE_CNT <= 1) begin
                                state    <= ST_HELD;
                                key_held <= 1'b1;
                            end else begin
                                state <= ST_PRESS_DB;
                            end
                        end
                    end
                    ST_PRESS_DB: begin
                        if (!frame_match) begin
                            state <= ST_IDLE;
                        end else if (db_cnt >= DB_LAST) begin
                            state    <= ST_HELD;
                            key_held <= 1'b1;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!frame_match) begin
                            if (DEBOUNCE_CNT <= 1) begin
                                state    <= ST_IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state  <= ST_RELEASE_DB;
                                db_cnt <= DB_ONE;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_due) begin
                            rep_cnt   <= '0;
                            rep_first <= 1'b0;
                        end else begin
                            rep_cnt <= rep_cnt + RP_ONE;
                        end
`endif
                    end
                    ST_RELEASE_DB: begin
                        if (frame_match) begin
                            state <= ST_HELD;
                        end else if (db_cnt >= DB_LAST) begin
                            state    <= ST_IDLE;
                            key_held <= 1'b0;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_CNT=8).
// A 16-cycle frame starts each time col_sel returns to 1110.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  col_sel;
    logic [3:0]  row_in;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_held;
    logic        overrun;
    logic [15:0] pressed;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // Matrix model: bit r*4+c of pressed shorts row r to column c.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(pressed[r*4 +: 4] & ~col_sel);
    end

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_CNT   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_sel   (col_sel),
        .row_in    (row_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] keys);
        pressed = keys;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ackKey();
        key_ack = 1'b1;
        waitNeg(1);
        key_ack = 1'b0;
    endtask

    // Returns at the first negedge of a new frame (col_sel just wrapped to 1110).
    task automatic alignFrame();
        logic [3:0] last;
        bit         found;
        found = 1'b0;
        last  = col_sel;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col_sel == 4'b1110 && last == 4'b0111)
                found = 1'b1;
            last = col_sel;
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL align_frame: got col_sel=%b, want a wrap to 1110 within 40 cycles", col_sel);
        end
    endtask

    // Monitor: a new key is presented when key_valid rises, or stays high across an acked edge.
    initial begin
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                prev_valid = 1'b0;
            end else begin
                if (key_valid && (!prev_valid || key_ack)) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_key: got code %0d, want no new key", key_code);
                    end else begin
                        checkOutput("key_code", 32'(key_code), 32'(exp_q.pop_front()));
                    end
                end
                prev_valid = key_valid;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 1000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_frames[$];
        int idx;
        logic [15:0] multi_pairs[2];

        reset   = 1'b0;
        key_ack = 1'b0;
        applyStimulus(16'h0000);

        // Reset state and first column advance
        waitNeg(3);
        checkOutput("rst_col_sel", 32'(col_sel), 32'(4'b1110));
        checkOutput("rst_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_code", 32'(key_code), 32'd0);
        checkOutput("rst_held", 32'(key_held), 32'd0);
        reset = 1'b1;
        waitNeg(3);
        checkOutput("col_sel_before_slot", 32'(col_sel), 32'(4'b1110));
        waitNeg(1);
        checkOutput("col_sel_first_slot", 32'(col_sel), 32'(4'b1101));

        // Debounced press of key 9 (row 2, column 1)
        $display("[TB] debounced press");
        alignFrame();
        applyStimulus(16'h0200);
        exp_q.push_back(9);
        waitNeg(47);
        checkOutput("press_valid_early", 32'(key_valid), 32'd0);
        waitNeg(1);
        checkOutput("press_valid", 32'(key_valid), 32'd1);
        checkOutput("press_held", 32'(key_held), 32'd1);
        waitNeg(32);
        ackKey();
        checkOutput("press_ack_clears", 32'(key_valid), 32'd0);
        checkOutput("press_still_held", 32'(key_held), 32'd1);
        applyStimulus(16'h0000);
        waitNeg(80);
        checkOutput("press_released", 32'(key_held), 32'd0);

        // Bounce: only two frames of contact
        $display("[TB] bounce");
        alignFrame();
        applyStimulus(16'h0040);
        waitNeg(32);
        applyStimulus(16'h0000);
        waitNeg(64);
        checkOutput("bounce_valid", 32'(key_valid), 32'd0);
        checkOutput("bounce_held", 32'(key_held), 32'd0);

        // Overrun: key 9 left unacknowledged, then key 4 debounced
        $display("[TB] overrun");
        alignFrame();
        applyStimulus(16'h0200);
        exp_q.push_back(9);
        waitNeg(64);
        applyStimulus(16'h0000);
        waitNeg(80);
        checkOutput("ovr_idle_held", 32'(key_held), 32'd0);
        alignFrame();
        applyStimulus(16'h0010);
        waitNeg(48);
        checkOutput("ovr_code_kept", 32'(key_code), 32'd9);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_valid", 32'(key_valid), 32'd1);
        applyStimulus(16'h0000);
        waitNeg(80);
        ackKey();
        checkOutput("ovr_ack_valid", 32'(key_valid), 32'd0);
        checkOutput("ovr_ack_flag", 32'(overrun), 32'd0);

        // Ack landing on the same edge as a new accept
        $display("[TB] ack and accept together");
        alignFrame();
        applyStimulus(16'h0008);
        exp_q.push_back(3);
        waitNeg(48);
        checkOutput("prio_first_valid", 32'(key_valid), 32'd1);
        applyStimulus(16'h0000);
        waitNeg(80);
        alignFrame();
        applyStimulus(16'h4000);
        exp_q.push_back(14);
        waitNeg(47);
        key_ack = 1'b1;
        waitNeg(1);
        key_ack = 1'b0;
        checkOutput("prio_code", 32'(key_code), 32'd14);
        checkOutput("prio_valid", 32'(key_valid), 32'd1);
        checkOutput("prio_overrun", 32'(overrun), 32'd0);
        applyStimulus(16'h0000);
        waitNeg(80);
        ackKey();

        // Multi-key: across columns (0+5) and within one column (1+13)
        $display("[TB] multi-key");
        multi_pairs[0] = 16'h0021;
        multi_pairs[1] = 16'h2002;
        for (int p = 0; p < 2; p++) begin
            alignFrame();
            applyStimulus(multi_pairs[p]);
            waitNeg(160);
            checkOutput("multi_valid", 32'(key_valid), 32'd0);
            checkOutput("multi_held", 32'(key_held), 32'd0);
            applyStimulus(16'h0000);
            waitNeg(32);
        end

        // Long hold of key 10 with an immediate consumer
        $display("[TB] long hold");
`ifdef KEYPAD_REPEAT_EN
        exp_frames = '{3, 11, 13, 15, 17, 19};
`else
        exp_frames = '{3};
`endif
        foreach (exp_frames[i])
            exp_q.push_back(10);
        idx = 0;
        alignFrame();
        applyStimulus(16'h0400);
        for (int c = 1; c <= 320; c++) begin
            @(negedge clk);
            if (key_valid && !key_ack) begin
                if (idx < exp_frames.size()) begin
                    checkOutput("hold_accept_cycle", 32'(c), 32'(exp_frames[idx] * 16));
                end else begin
                    total++;
                    bad++;
                    $display("[TB] FAIL hold_extra_accept: got accept at cycle %0d, want none", c);
                end
                idx++;
                key_ack = 1'b1;
            end else begin
                key_ack = 1'b0;
            end
        end
        key_ack = 1'b0;
        applyStimulus(16'h0000);
        checkOutput("hold_accept_count", 32'(idx), 32'(exp_frames.size()));
        waitNeg(96);
        checkOutput("hold_released", 32'(key_held), 32'd0);

        // Reset while a key is pending
        $display("[TB] reset mid-operation");
        alignFrame();
        applyStimulus(16'h0200);
        exp_q.push_back(9);
        waitNeg(48);
        reset = 1'b0;
        applyStimulus(16'h0000);
        waitNeg(1);
        checkOutput("midrst_valid", 32'(key_valid), 32'd0);
        checkOutput("midrst_held", 32'(key_held), 32'd0);
        checkOutput("midrst_code", 32'(key_code), 32'd0);
        checkOutput("midrst_col_sel", 32'(col_sel), 32'(4'b1110));
        reset = 1'b1;
        waitNeg(4);
        checkOutput("midrst_restart_col", 32'(col_sel), 32'(4'b1101));

        waitNeg(4);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
